// File: rtl/rtfifo_spi_master_pkg.sv
// Shared types and helpers for the FIFO-to-SPI link master.
// Optional mode select is enabled with the RTFIFO_SPI_MODE_SEL_EN macro.
package rtfifo_spi_master_pkg;

  localparam int unsigned StateW  = 5;
  localparam int unsigned BitCntW = 3;

  // One-hot state encoding; StIdle is the reset state.
  typedef enum logic [StateW-1:0] {
    StIdle  = 5'b00001,
    StLoad  = 5'b00010,
    StShift = 5'b00100,
    StStore = 5'b01000,
    StGap   = 5'b10000
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r++;
    end
    return r;
  endfunction

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned div_width(input int unsigned v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/rtfifo_spi_sck_gen.sv
// SCK divider: toggles SCK every pDiv cycles while enabled and flags the
// leading/trailing edges one cycle ahead of the registered SCK change.
module rtfifo_spi_sck_gen
  import rtfifo_spi_master_pkg::*;
#(
  parameter int unsigned pDiv = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic idle_lvl_i,
  output logic sck_o,
  output logic lead_o,
  output logic trail_o
);

  localparam int unsigned DivW = div_width(pDiv);

  logic [DivW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;
  logic            tick;

  assign tick    = en_i && (cnt_q == DivW'(pDiv - 1));
  assign lead_o  = tick && (sck_q == idle_lvl_i);
  assign trail_o = tick && (sck_q != idle_lvl_i);
  assign sck_o   = sck_q;

  always_comb begin
    cnt_d = '0;
    sck_d = idle_lvl_i;
    if (en_i) begin
      cnt_d = tick ? '0 : cnt_q + DivW'(1);
      sck_d = tick ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/rtfifo_spi_master.sv
// Pops bytes from the Tx FIFO, exchanges each over an SPI master port and
// pushes the received byte to the Rx FIFO. Mode select: RTFIFO_SPI_MODE_SEL_EN.
module rtfifo_spi_master
  import rtfifo_spi_master_pkg::*;
#(
  parameter int unsigned pDiv      = 4,
  parameter int unsigned pFIFO_Gap = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       TF_EF,
  input  logic [7:0] TDO,
  output logic       TF_Rd,
  input  logic       RF_FF,
  output logic [7:0] RDI,
  output logic       RF_Wr,
  output logic       SCK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS_n,
  output logic       Busy
`ifdef RTFIFO_SPI_MODE_SEL_EN
  ,
  input  logic       CPOL,
  input  logic       CPHA
`endif
);

  localparam int unsigned GapW = div_width(pFIFO_Gap + 1);

  state_e             state_q, state_d;
  logic [7:0]         tx_sr_q, tx_sr_d;
  logic [7:0]         rx_sr_q, rx_sr_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [7:0]         rdi_q, rdi_d;
  logic               tf_rd_q, tf_rd_d;
  logic               rf_wr_q, rf_wr_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               cpol_in, cpha_in;
  logic               lead, trail, sample, shift_out;

`ifdef RTFIFO_SPI_MODE_SEL_EN
  assign cpol_in = CPOL;
  assign cpha_in = CPHA;
`else
  assign cpol_in = 1'b0;
  assign cpha_in = 1'b0;
`endif

  rtfifo_spi_sck_gen #(
    .pDiv(pDiv)
  ) u_sck_gen (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .en_i      (state_q == StShift),
    .idle_lvl_i(cpol_q),
    .sck_o     (SCK),
    .lead_o    (lead),
    .trail_o   (trail)
  );

  // CPHA=0 samples on the leading edge and shifts on the trailing; CPHA=1 swaps.
  assign sample    = cpha_q ? trail : lead;
  assign shift_out = cpha_q ? lead : trail;

  always_comb begin
    state_d   = state_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    bit_cnt_d = bit_cnt_q;
    rdi_d     = rdi_q;
    ss_n_d    = ss_n_q;
    mosi_d    = mosi_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tf_rd_d   = 1'b0;
    rf_wr_d   = 1'b0;
    gap_d     = (gap_q != '0) ? gap_q - GapW'(1) : '0;

    unique case (state_q)
      StIdle: begin
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        cpol_d = cpol_in;
        cpha_d = cpha_in;
        if (En && !TF_EF) begin
          state_d = StLoad;
          tf_rd_d = 1'b1;
        end
      end
      StLoad: begin
        tx_sr_d   = TDO;
        mosi_d    = TDO[7];
        ss_n_d    = 1'b0;
        rx_sr_d   = '0;
        bit_cnt_d = '0;
        gap_d     = GapW'(pFIFO_Gap);
        state_d   = StShift;
      end
      StShift: begin
        if (shift_out) begin
          mosi_d  = cpha_q ? tx_sr_q[7] : tx_sr_q[6];
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
        if (sample) begin
          rx_sr_d = {rx_sr_q[6:0], MISO};
        end
        if (trail) begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (bit_cnt_q == '1) begin
            state_d = StStore;
          end
        end
      end
      StStore: begin
        if (!RF_FF && (gap_q == '0)) begin
          rf_wr_d = 1'b1;
          rdi_d   = rx_sr_q;
          gap_d   = GapW'(pFIFO_Gap);
          state_d = StGap;
        end
      end
      StGap: begin
        // Leave on the cycle the counter reaches zero so the byte period is exact.
        if (gap_q <= GapW'(1)) begin
          if (En && !TF_EF) begin
            state_d = StLoad;
            tf_rd_d = 1'b1;
          end else begin
            state_d = StIdle;
            ss_n_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        ss_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= StIdle;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      rdi_q     <= '0;
      tf_rd_q   <= 1'b0;
      rf_wr_q   <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      rdi_q     <= rdi_d;
      tf_rd_q   <= tf_rd_d;
      rf_wr_q   <= rf_wr_d;
      ss_n_q    <= ss_n_d;
      mosi_q    <= mosi_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
    end
  end

  assign TF_Rd = tf_rd_q;
  assign RF_Wr = rf_wr_q;
  assign RDI   = rdi_q;
  assign SS_n  = ss_n_q;
  assign MOSI  = mosi_q;
  assign Busy  = (state_q != StIdle);

endmodule
